syscall_unit: RTL
=================

Name: syscall_unit

Overview:
- Parametrised multi-cycle system-call engine. Replaces the flat per-code decode strobes with a sequencer that performs each service itself.
- Decodes the syscall code from the instruction when the CPU's Syscalls line is high and stalls the CPU while it runs.
- Reads data memory and streams output beats to the console/testbench port over a valid/ready handshake. get_int writes its result back to the accumulator.

Parameters:
- DATA_W, 8: accumulator/memory/register word width.
- ADDR_W, 8: data-memory address width.
- NUM_REGS, 4: registers dumped by print_regs.
- STACK_TOP, 8'hFF: highest stack address (stack grows down).
- DATA_BASE, 8'h00: reset value of get_int read pointer.
- MAX_STR, 64: maximum characters emitted per print_string.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- instr  in  16  current instruction; code = instr[2:0]
- Syscalls  in  1  syscall request qualifier
- acc  in  DATA_W  accumulator value
- sp  in  ADDR_W  current stack pointer (next free slot)
- regs_flat  in  NUM_REGS*DATA_W  register file snapshot; reg i = bits [i*DATA_W +: DATA_W]
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_W  beat payload
- out_kind  out  2  0=INT, 1=CHAR, 2=REG, 3=STACK
- acc_wr_en  out  1  one-cycle accumulator write strobe
- acc_wr_data  out  DATA_W  value for accumulator
- stall  out  1  CPU must hold instruction
- done  out  1  one-cycle pulse at service completion
- bad_code  out  1  one-cycle pulse for an unsupported code

Behaviour:
- Codes:
  - 001 print_string
  - 010 get_int
  - 100 print_acc
  - 101 print_regs
  - 110 print_stack
  - 000, 011 and 111 are unsupported.
- Reset (synchronous, active-high): state=IDLE; all outputs 0; get_int pointer gptr=DATA_BASE; internal counters 0. Reset in any state aborts the service immediately and drops any pending beat without handshake.
- Request acceptance:
  - Accepted only in IDLE with Syscalls=1.
  - stall is combinational: (IDLE & Syscalls & supported code) | (state != IDLE). It is therefore high in the request cycle.
  - On acceptance, latch the code, acc and sp.
  - An unsupported code pulses bad_code for one cycle, raises no stall and leaves the state unchanged.
  - Syscalls is ignored outside IDLE.
- States: IDLE, FETCH, CAPTURE, EMIT, FINISH.
  - FETCH: mem_rd_en=1 with mem_addr driven.
  - CAPTURE: latch mem_rdata.
  - EMIT: out_valid=1; out_data, out_kind and out_valid are held stable until out_ready is sampled high.
  - FINISH: done=1 for one cycle and stall=1, then go to IDLE.
- print_acc: IDLE -> EMIT (INT, latched acc) -> FINISH. Minimum 3 cycles including FINISH.
- print_regs: EMIT NUM_REGS beats (REG), reg 0 first, then FINISH.
- get_int: FETCH at gptr -> CAPTURE -> FINISH, with acc_wr_en=1 and acc_wr_data=captured word in the FINISH cycle. gptr increments mod 2^ADDR_W. No output beat.
- print_string:
  - Pointer starts at latched acc.
  - Loop FETCH -> CAPTURE. A captured byte of 0 goes to FINISH and is not emitted; otherwise EMIT (CHAR), then pointer+1 and FETCH.
  - The pointer wraps mod 2^ADDR_W.
  - Terminates after MAX_STR emitted characters even without a 0.
- print_stack:
  - Address starts at STACK_TOP and decrements. Emit mem[STACK_TOP] down to mem[latched sp+1] as STACK beats.
  - If latched sp >= STACK_TOP, go directly to FINISH with no beats.
- Back-pressure: out_ready=0 holds EMIT indefinitely with no memory reads. A beat transfers on the cycle out_valid & out_ready.
- mem_rd_en is asserted only in FETCH. mem_addr holds its last value otherwise.

Test Plan:
- Reset, then Syscalls=1, instr[2:0]=100, acc=8'h2A, out_ready=1 -> stall=1 same cycle; one beat INT 0x2A; done pulse; stall=0 afterwards.
- print_string: acc=8'h10, mem[10..13]="Hi!",0, out_ready toggling 1/0 -> beats CHAR 0x48, 0x69, 0x21 in order; no 0x00 beat; payload stable while unready.
- print_stack: STACK_TOP=FF, sp=FC, mem[FF]=7, mem[FE]=8, mem[FD]=9 -> STACK beats 7, 8, 9 then done. Repeat with sp=FF -> zero beats, done.
- get_int twice: mem[00]=5, mem[01]=6 -> acc_wr_en pulses with 5 then 6; no out_valid. After reset, next get_int returns 5 again.
- print_regs: NUM_REGS=4, regs_flat=32'h04030201 -> REG beats 01, 02, 03, 04. Code 111 -> bad_code pulse, stall=0, no beats.
- Reset asserted mid-print_string during EMIT -> next cycle out_valid=0, stall=0, state IDLE; a new print_acc request is then serviced normally.

Source files
------------

// File: rtl/syscall_unit.sv
// syscall_unit: multi-cycle syscall sequencer that reads memory, streams output beats and writes get_int results back.
module syscall_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NUM_REGS = 4,
  parameter logic [ADDR_W-1:0] STACK_TOP = 8'hFF,
  parameter logic [ADDR_W-1:0] DATA_BASE = 8'h00,
  parameter int MAX_STR = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                instr,
  input  logic                       Syscalls,
  input  logic [DATA_W-1:0]          acc,
  input  logic [ADDR_W-1:0]          sp,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [1:0]                 out_kind,
  output logic                       acc_wr_en,
  output logic [DATA_W-1:0]          acc_wr_data,
  output logic                       stall,
  output logic                       done,
  output logic                       bad_code
);
  localparam logic [2:0] C_STR = 3'b001, C_GET = 3'b010, C_ACC = 3'b100, C_REG = 3'b101, C_STK = 3'b110;
  localparam int CW = $clog2(MAX_STR > NUM_REGS ? MAX_STR : NUM_REGS) + 1;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT, FINISH} state_t;
  state_t state, state_n;
  logic [2:0] code, req;
  logic [ADDR_W-1:0] l_sp, addr, gptr;
  logic [DATA_W-1:0] data;
  logic [NUM_REGS*DATA_W-1:0] rq;
  logic [CW-1:0] cnt;
  logic ok, accept, xfer, last, unused;
  assign req = instr[2:0];
  assign unused = &{1'b0, instr[15:3]};
  assign ok = req inside {C_STR, C_GET, C_ACC, C_REG, C_STK};
  assign accept = state == IDLE && Syscalls && ok;
  assign xfer = state == EMIT && out_ready;
  assign last = code == C_ACC || (code == C_REG && cnt == CW'(NUM_REGS - 1)) ||
                (code == C_STR && cnt == CW'(MAX_STR - 1)) || (code == C_STK && addr == l_sp + 1'b1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (req == C_ACC || req == C_REG) ? EMIT :
                                     (req == C_STK && sp >= STACK_TOP) ? FINISH : FETCH;
      FETCH:   state_n = CAPTURE;
      CAPTURE: state_n = (code == C_GET || (code == C_STR && mem_rdata == '0)) ? FINISH : EMIT;
      EMIT:    if (out_ready) state_n = last ? FINISH : code == C_REG ? EMIT : FETCH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      code <= '0;
      l_sp <= '0;
      addr <= '0;
      data <= '0;
      rq <= '0;
      cnt <= '0;
      gptr <= DATA_BASE;
    end else begin
      state <= state_n;
      if (accept) begin
        code <= req;
        l_sp <= sp;
        cnt <= '0;
        data <= req == C_REG ? regs_flat[DATA_W-1:0] : acc;
        rq <= regs_flat >> DATA_W;
        addr <= req == C_GET ? gptr : req == C_STR ? ADDR_W'(acc) :
                (req == C_STK && sp < STACK_TOP) ? STACK_TOP : addr;
      end
      if (state == CAPTURE) begin
        data <= mem_rdata;
        if (code == C_GET) gptr <= gptr + 1'b1;
      end
      if (xfer) begin
        cnt <= cnt + 1'b1;
        data <= rq[DATA_W-1:0];
        rq <= rq >> DATA_W;
        // advance the read pointer only when another fetch follows
        if (!last) addr <= code == C_STK ? addr - 1'b1 : code == C_STR ? addr + 1'b1 : addr;
      end
    end
  end
  assign stall = accept || state != IDLE;
  assign bad_code = state == IDLE && Syscalls && !ok;
  assign mem_rd_en = state == FETCH;
  assign mem_addr = addr;
  assign out_valid = state == EMIT;
  assign out_data = out_valid ? data : '0;
  assign out_kind = !out_valid ? 2'd0 : code == C_ACC ? 2'd0 : code == C_STR ? 2'd1 : code == C_REG ? 2'd2 : 2'd3;
  assign done = state == FINISH;
  assign acc_wr_en = done && code == C_GET;
  assign acc_wr_data = acc_wr_en ? data : '0;
endmodule
